// File: rtl/round_robin_arbiter.sv
// Four-requester round-robin arbiter with a registered one-hot grant and a hold-time limit.
// A requester that keeps asking is revoked after MAX_HOLD cycles, and the preempt output pulses once.
module round_robin_arbiter #(
   parameter int unsigned MAX_HOLD = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] go,
   output logic [3:0] get,
   output logic [1:0] get_id,
   output logic       busy,
   output logic       preempt
);

   localparam int unsigned NREQ       = 4;
   localparam int unsigned HOLD_CLAMP = (MAX_HOLD < 1) ? 1 : ((MAX_HOLD > 15) ? 15 : MAX_HOLD);
   localparam logic [3:0]  HOLD_LIMIT = 4'(HOLD_CLAMP);

   typedef enum logic {
      IDLE = 1'b0,
      OWN  = 1'b1
   } state_t;

   state_t      state_reg,    state_next;
   logic [1:0]  ptr_reg,      ptr_next;
   logic [3:0]  hold_cnt_reg, hold_cnt_next;
   logic [3:0]  get_reg,      get_next;
   logic [1:0]  get_id_reg,   get_id_next;
   logic        busy_reg,     busy_next;
   logic        preempt_reg,  preempt_next;

   logic [3:0]  go_rot;
   logic [1:0]  offset;
   logic        any_req;
   logic [1:0]  winner;
   logic [3:0]  winner_onehot;
   logic        owner_req;
   logic        hold_expired;
   logic        rearb;

   // go_rot[k] is the request seen at search position k, counting from ptr.
   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_rot
         logic [1:0] idx;
         assign idx        = ptr_reg + 2'(gi);
         assign go_rot[gi] = go[idx];
      end
   endgenerate

   always_comb begin
      offset  = 2'd0;
      any_req = |go_rot;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (go_rot[k]) begin
            offset = 2'(k);
         end
      end
   end

   assign winner = ptr_reg + offset;

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_dec
         assign winner_onehot[gi] = (winner == 2'(gi));
      end
   endgenerate

   assign owner_req    = go[get_id_reg];
   assign hold_expired = (hold_cnt_reg >= HOLD_LIMIT);

   always_comb begin
      state_next    = state_reg;
      ptr_next      = ptr_reg;
      hold_cnt_next = hold_cnt_reg;
      get_next      = get_reg;
      get_id_next   = get_id_reg;
      preempt_next  = 1'b0;
      rearb         = 1'b0;

      case (state_reg)
         IDLE: begin
            rearb = 1'b1;
         end
         OWN: begin
            if (!owner_req) begin
               rearb = 1'b1;
            end else if (hold_expired) begin
               rearb        = 1'b1;
               preempt_next = 1'b1;
            end else begin
               hold_cnt_next = hold_cnt_reg + 4'd1;
            end
         end
         default: begin
            rearb = 1'b1;
         end
      endcase

      // ptr already points past the outgoing owner, so a timed-out owner is searched last.
      if (rearb) begin
         if (any_req) begin
            state_next    = OWN;
            get_next      = winner_onehot;
            get_id_next   = winner;
            ptr_next      = winner + 2'd1;
            hold_cnt_next = 4'd1;
         end else begin
            state_next    = IDLE;
            get_next      = 4'd0;
            get_id_next   = 2'd0;
            hold_cnt_next = 4'd0;
         end
      end

      busy_next = |get_next;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         ptr_reg      <= 2'd0;
         hold_cnt_reg <= 4'd0;
         get_reg      <= 4'd0;
         get_id_reg   <= 2'd0;
         busy_reg     <= 1'b0;
         preempt_reg  <= 1'b0;
      end else begin
         state_reg    <= state_next;
         ptr_reg      <= ptr_next;
         hold_cnt_reg <= hold_cnt_next;
         get_reg      <= get_next;
         get_id_reg   <= get_id_next;
         busy_reg     <= busy_next;
         preempt_reg  <= preempt_next;
      end
   end

   assign get     = get_reg;
   assign get_id  = get_id_reg;
   assign busy    = busy_reg;
   assign preempt = preempt_reg;

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Bench for round_robin_arbiter: an owner/pointer model checked every cycle, plus directed
// scenarios with hand-computed grants.
module tb_round_robin_arbiter;

   localparam int MAX_HOLD = 4;

   logic       clk;
   logic       rst_n;
   logic [3:0] go;
   logic [3:0] get;
   logic [1:0] get_id;
   logic       busy;
   logic       preempt;

   int checks = 0;
   int errors = 0;

   round_robin_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .go      (go),
      .get     (get),
      .get_id  (get_id),
      .busy    (busy),
      .preempt (preempt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model state: the current owner (-1 when there is none), the search start, and the grant age.
   int m_owner = -1;
   int m_ptr   = 0;
   int m_hold  = 0;
   int m_pre   = 0;
   int run_len = 0;
   logic [3:0] prev_get = 4'd0;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_owner = -1;
         m_ptr   = 0;
         m_hold  = 0;
         m_pre   = 0;
      end else begin
         bit again;
         again = 0;
         m_pre = 0;
         if (m_owner < 0) again = 1;
         else if (!go[m_owner]) again = 1;
         else if (m_hold == MAX_HOLD) begin
            again = 1;
            m_pre = 1;
         end else m_hold++;
         if (again) begin
            m_owner = -1;
            m_hold  = 0;
            for (int k = 0; k < 4; k++) begin
               int c;
               c = (m_ptr + k) % 4;
               if (m_owner < 0 && go[c]) m_owner = c;
            end
            if (m_owner >= 0) begin
               m_ptr  = (m_owner + 1) % 4;
               m_hold = 1;
            end
         end
      end
      #1;
      check("model_get", int'(get), (m_owner < 0) ? 0 : (1 << m_owner));
      check("model_get_id", int'(get_id), (m_owner < 0) ? 0 : m_owner);
      check("model_busy", int'(busy), (m_owner >= 0) ? 1 : 0);
      check("model_preempt", int'(preempt), m_pre);
      check("onehot0_get", int'($onehot0(get)), 1);
      if (get != 4'd0 && get == prev_get && !preempt) run_len++;
      else run_len = (get != 4'd0) ? 1 : 0;
      check("hold_len_le_max", int'(run_len <= MAX_HOLD), 1);
      prev_get = get;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      go    = 4'd0;
      tick(1);
      rst_n = 1'b1;
   endtask

   task automatic expect_out(input string name, input logic [3:0] eg, input logic ep);
      check({name, "_get"}, int'(get), int'(eg));
      check({name, "_preempt"}, int'(preempt), int'(ep));
   endtask

   logic [3:0] tbl [12] = '{4'b1010, 4'b0110, 4'b1111, 4'b0001, 4'b1000, 4'b1001,
                             4'b0111, 4'b0000, 4'b1100, 4'b0011, 4'b1110, 4'b0101};

   initial begin
      rst_n = 1'b0;
      go    = 4'd0;
      tick(2);
      expect_out("reset", 4'b0000, 1'b0);
      check("reset_busy", int'(busy), 0);
      check("reset_get_id", int'(get_id), 0);
      rst_n = 1'b1;

      // single requester: continuous grant with a preempt pulse at each timeout
      go = 4'b0001;
      tick(1);
      expect_out("single_first", 4'b0001, 1'b0);
      tick(4);
      expect_out("single_timeout", 4'b0001, 1'b1);
      tick(1);
      expect_out("single_after", 4'b0001, 1'b0);
      go = 4'b0000;
      tick(1);
      expect_out("single_release", 4'b0000, 1'b0);

      // full contention rotates through every requester
      do_reset();
      go = 4'b1111;
      tick(1);
      expect_out("cont_0", 4'b0001, 1'b0);
      tick(4);
      expect_out("cont_1", 4'b0010, 1'b1);
      tick(4);
      expect_out("cont_2", 4'b0100, 1'b1);
      tick(4);
      expect_out("cont_3", 4'b1000, 1'b1);
      tick(4);
      expect_out("cont_4", 4'b0001, 1'b1);

      // early release hands over with no gap and no preempt
      do_reset();
      go = 4'b0011;
      tick(2);
      expect_out("early_hold", 4'b0001, 1'b0);
      go = 4'b0010;
      tick(1);
      expect_out("early_next", 4'b0010, 1'b0);

      // pointer fairness: after requester 2, the search starts at 3 and wraps to 0
      do_reset();
      go = 4'b0100;
      tick(1);
      expect_out("fair_own2", 4'b0100, 1'b0);
      go = 4'b0000;
      tick(1);
      expect_out("fair_idle", 4'b0000, 1'b0);
      go = 4'b0101;
      tick(1);
      expect_out("fair_wrap", 4'b0001, 1'b0);

      // non-owner requests are ignored, then reset drops the grant mid-hold
      do_reset();
      go = 4'b0100;
      tick(1);
      go = 4'b1111;
      tick(1);
      expect_out("ignore_others", 4'b0100, 1'b0);
      rst_n = 1'b0;
      tick(1);
      expect_out("midreset", 4'b0000, 1'b0);
      check("midreset_busy", int'(busy), 0);
      rst_n = 1'b1;
      tick(1);
      expect_out("post_reset", 4'b0001, 1'b0);

      // mixed request patterns, checked by the model every cycle
      for (int i = 0; i < 12; i++) begin
         go = tbl[i];
         tick(3);
      end
      go = 4'b0000;
      tick(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule

// File: doc/round_robin_arbiter.md
ROUND_ROBIN_ARBITER -- requirements
Module: round_robin_arbiter

Interface
REQ-001 Parameter: MAX_HOLD, 4, maximum consecutive cycles one requester may hold the grant (legal range 1..15).
REQ-002 Port: clk  input  1  sole clock; all state changes on rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port: go  input  4  request vector; go[i]=1 means requester i wants the shared resource.
REQ-005 Port: get  output  4  registered one-hot grant vector; all zero when no grant.
REQ-006 Port: get_id  output  2  index of the granted requester; 0 when get is all zero.
REQ-007 Port: busy  output  1  high whenever get is non-zero.
REQ-008 Port: preempt  output  1  one-cycle pulse, registered, on the cycle a grant is revoked by hold timeout.

Function
REQ-009 The block SHALL implement two states, IDLE (no grant) and OWN (one grant active).
REQ-010 Arbitration SHALL search go cyclically starting at pointer ptr (2 bits), i.e. order ptr, ptr+1, ptr+2, ptr+3 mod 4; the first asserted bit wins.
REQ-011 IDLE: if any go bit is set at a rising edge, the block SHALL enter OWN with get = one-hot(winner) on that edge (1-cycle request-to-grant latency); otherwise it SHALL stay IDLE with get=0.
REQ-012 On every new grant, ptr SHALL be set to winner+1 mod 4 and the hold counter hold_cnt SHALL be set to 1.
REQ-013 OWN: while go[owner]=1 and hold_cnt < MAX_HOLD, get SHALL be unchanged and hold_cnt SHALL increment by 1 per cycle.
REQ-014 Release: if go[owner]=0 at an edge, the grant SHALL end on that edge; the block SHALL re-arbitrate the same edge and grant the next winner (no idle gap) or go to IDLE if go=0.
REQ-015 Timeout: if go[owner]=1 and hold_cnt = MAX_HOLD at an edge, the grant SHALL be revoked on that edge, preempt SHALL be 1 for exactly the following cycle, and re-arbitration SHALL proceed per REQ-010 and REQ-012; the owner is then lowest priority and SHALL be re-granted only if no other go bit is set.
REQ-016 A grant SHALL never be held for more than MAX_HOLD consecutive cycles without re-arbitration; get SHALL always be zero or one-hot.
REQ-017 hold_cnt SHALL be 4 bits wide and SHALL NOT wrap; it is reloaded to 1 on every grant, including a re-grant to the same requester.
REQ-018 Changes to go bits of non-owners SHALL have no effect during OWN until the next release or timeout.
REQ-019 get_id and busy SHALL be registered and consistent with get every cycle.

Reset
REQ-020 When rst_n=0 at a rising edge, the block SHALL go to IDLE with get=0, get_id=0, busy=0, preempt=0, ptr=0, hold_cnt=0, regardless of go or current state.
REQ-021 Reset asserted mid-grant SHALL drop the grant on that edge; after rst_n returns to 1, arbitration SHALL restart with requester 0 at highest priority.

Verification
REQ-022 Single requester: go=0001 from cycle 1, MAX_HOLD=4 -> get=0001 from cycle 2, preempt pulse after 4 cycles, immediate re-grant get=0001, no gap.
REQ-023 Contention: go=1111 held -> grant order 0001, 0010, 0100, 1000, 0001, each held exactly 4 cycles, preempt pulse at each hand-over.
REQ-024 Early release: go=0011, owner 0 drops go[0] after 2 grant cycles -> get=0010 on the next edge, preempt stays 0.
REQ-025 Pointer fairness: grant to 2 completes, then go=0101 -> get=0001 (search starts at 3, wraps to 0).
REQ-026 Reset mid-grant: get=0100, rst_n=0 one cycle with go=1111 -> get=0000, busy=0, then get=0001 on the first edge after release.
REQ-027 All scenarios SHALL check every cycle that get is zero or one-hot and that no grant exceeds MAX_HOLD cycles.
